// File: rtl/round_score_counter.sv
// Times one game round, keeps a saturating two-digit BCD score from hit/miss
// edges, then hands the result to the scoring block as STORE followed by SHOW.
module round_score_counter #(
    parameter int ROUND_CYCLES = 500,
    parameter bit PENALTY_EN   = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       hit,
    input  logic       miss,
    input  logic [2:0] playerID,
    input  logic       guestIn,
    output logic [2:0] controlSig,
    output logic       isGuest,
    output logic [2:0] intIDin,
    output logic [3:0] scoreOnes,
    output logic [3:0] scoreTens,
    output logic       busy
);
    localparam int TW = $clog2(ROUND_CYCLES + 1);
    localparam logic [TW-1:0] LAST_TICK = TW'(ROUND_CYCLES - 1);

    localparam logic [2:0] CMD_NOP   = 3'b000;
    localparam logic [2:0] CMD_STORE = 3'b001;
    localparam logic [2:0] CMD_SHOW  = 3'b010;
    localparam logic [2:0] CMD_CLEAR = 3'b100;

    typedef enum logic [2:0] {IDLE, CLR, PLAY, REPORT, SHOW} state_t;

    state_t        state_reg, state_next;
    logic [TW-1:0] timer_reg;
    logic [3:0]    ones_reg, ones_next;
    logic [3:0]    tens_reg, tens_next;
    logic [2:0]    ctrl_reg, ctrl_next;
    logic          busy_reg;
    logic [2:0]    id_reg;
    logic          guest_reg;

    logic [2:0] in_vec;
    logic [2:0] evt;
    logic       start_evt, hit_evt, miss_evt;
    logic       do_inc, do_dec;

    assign in_vec = {miss, hit, start};

    // Each input is sampled once, then compared against its previous sample.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_edge
            logic cur_reg;
            logic prev_reg;
            always_ff @(posedge clk) begin
                if (!rst) begin
                    cur_reg  <= 1'b0;
                    prev_reg <= 1'b0;
                end else begin
                    cur_reg  <= in_vec[gi];
                    prev_reg <= cur_reg;
                end
            end
            assign evt[gi] = cur_reg & ~prev_reg;
        end
    endgenerate

    assign start_evt = evt[0];
    assign hit_evt   = evt[1];
    assign miss_evt  = evt[2];

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start_evt) state_next = CLR;
            CLR:     state_next = PLAY;
            PLAY:    if (timer_reg == LAST_TICK) state_next = REPORT;
            REPORT:  state_next = SHOW;
            SHOW:    if (start_evt) state_next = CLR;
            default: state_next = IDLE;
        endcase
    end

    // Command and busy are registered from the next state so they line up
    // with the state they describe.
    always_comb begin
        ctrl_next = CMD_NOP;
        case (state_next)
            CLR:     ctrl_next = CMD_CLEAR;
            REPORT:  ctrl_next = CMD_STORE;
            SHOW:    ctrl_next = CMD_SHOW;
            default: ctrl_next = CMD_NOP;
        endcase
    end

    // A simultaneous hit and miss cancel only when misses carry a penalty.
    always_comb begin
        ones_next = ones_reg;
        tens_next = tens_reg;
        do_inc    = hit_evt && (!miss_evt || !PENALTY_EN);
        do_dec    = PENALTY_EN && miss_evt && !hit_evt;
        if (state_reg == CLR) begin
            ones_next = 4'd0;
            tens_next = 4'd0;
        end else if (state_reg == PLAY) begin
            if (do_inc && !(tens_reg == 4'd9 && ones_reg == 4'd9)) begin
                if (ones_reg == 4'd9) begin
                    ones_next = 4'd0;
                    tens_next = tens_reg + 4'd1;
                end else begin
                    ones_next = ones_reg + 4'd1;
                end
            end else if (do_dec && !(tens_reg == 4'd0 && ones_reg == 4'd0)) begin
                if (ones_reg == 4'd0) begin
                    ones_next = 4'd9;
                    tens_next = tens_reg - 4'd1;
                end else begin
                    ones_next = ones_reg - 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= IDLE;
            timer_reg <= '0;
            ones_reg  <= 4'd0;
            tens_reg  <= 4'd0;
            ctrl_reg  <= CMD_NOP;
            busy_reg  <= 1'b0;
            id_reg    <= 3'd0;
            guest_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            ones_reg  <= ones_next;
            tens_reg  <= tens_next;
            ctrl_reg  <= ctrl_next;
            busy_reg  <= (state_next == PLAY);
            if (state_reg == CLR) begin
                timer_reg <= '0;
                id_reg    <= playerID;
                guest_reg <= guestIn;
            end else if (state_reg == PLAY) begin
                timer_reg <= timer_reg + TW'(1);
            end
        end
    end

    assign controlSig = ctrl_reg;
    assign busy       = busy_reg;
    assign scoreOnes  = ones_reg;
    assign scoreTens  = tens_reg;
    assign intIDin    = id_reg;
    assign isGuest    = guest_reg;

endmodule

// File: tb/tb_round_score_counter.sv
// Bench for round_score_counter: a short round with penalties (dut_a) and a long
// round without penalties (dut_b) share stimulus and are checked against a round-level model.
module tb_round_score_counter;
    localparam int RA = 50;
    localparam int RB = 230;
    localparam int M_IDLE = 0, M_CLR = 1, M_PLAY = 2, M_REPORT = 3, M_SHOW = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0, hit = 1'b0, miss = 1'b0;
    logic [2:0] playerID = 3'd0;
    logic       guestIn = 1'b0;

    logic [2:0] ctrl_a, ctrl_b, id_a, id_b;
    logic       guest_a, guest_b, busy_a, busy_b;
    logic [3:0] ones_a, tens_a, ones_b, tens_b;

    int vectors = 0;
    int miscompares = 0;

    logic sch_s[256];
    logic sch_h[256];
    logic sch_m[256];

    always #5 clk = ~clk;

    round_score_counter #(.ROUND_CYCLES(RA), .PENALTY_EN(1'b1)) dut_a (
        .clk(clk), .rst(rst), .start(start), .hit(hit), .miss(miss),
        .playerID(playerID), .guestIn(guestIn), .controlSig(ctrl_a),
        .isGuest(guest_a), .intIDin(id_a), .scoreOnes(ones_a),
        .scoreTens(tens_a), .busy(busy_a)
    );

    round_score_counter #(.ROUND_CYCLES(RB), .PENALTY_EN(1'b0)) dut_b (
        .clk(clk), .rst(rst), .start(start), .hit(hit), .miss(miss),
        .playerID(playerID), .guestIn(guestIn), .controlSig(ctrl_b),
        .isGuest(guest_b), .intIDin(id_b), .scoreOnes(ones_b),
        .scoreTens(tens_b), .busy(busy_b)
    );

    // Reference model: integer score clamped to 0..99, rounds counted down in cycles.
    int         m_mode[2]  = '{0, 0};
    int         m_score[2] = '{0, 0};
    int         m_left[2]  = '{0, 0};
    logic [2:0] m_id[2]    = '{3'd0, 3'd0};
    logic       m_guest[2] = '{1'b0, 1'b0};
    logic [2:0] h1 = 3'd0, h2 = 3'd0;
    logic [2:0] ev;
    assign ev = h1 & ~h2;

    function automatic int bound99(input int v);
        return (v < 0) ? 0 : (v > 99) ? 99 : v;
    endfunction

    always @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < 2; k++) begin
                m_mode[k]  <= M_IDLE;
                m_score[k] <= 0;
                m_left[k]  <= 0;
                m_id[k]    <= 3'd0;
                m_guest[k] <= 1'b0;
            end
            h1 <= 3'd0;
            h2 <= 3'd0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                case (m_mode[k])
                    M_IDLE: if (ev[0]) m_mode[k] <= M_CLR;
                    M_CLR: begin
                        m_mode[k]  <= M_PLAY;
                        m_score[k] <= 0;
                        m_left[k]  <= (k == 0) ? RA : RB;
                        m_id[k]    <= playerID;
                        m_guest[k] <= guestIn;
                    end
                    M_PLAY: begin
                        m_score[k] <= bound99(m_score[k] + (ev[1] ? 1 : 0)
                                              - ((ev[2] && k == 0) ? 1 : 0));
                        m_left[k] <= m_left[k] - 1;
                        if (m_left[k] == 1) m_mode[k] <= M_REPORT;
                    end
                    M_REPORT: m_mode[k] <= M_SHOW;
                    M_SHOW:   if (ev[0]) m_mode[k] <= M_CLR;
                    default:  m_mode[k] <= M_IDLE;
                endcase
            end
            h2 <= h1;
            h1 <= {miss, hit, start};
        end
    end

    function automatic logic [15:0] exp_one(input int k);
        logic [2:0] c;
        c = (m_mode[k] == M_CLR)    ? 3'b100 :
            (m_mode[k] == M_REPORT) ? 3'b001 :
            (m_mode[k] == M_SHOW)   ? 3'b010 : 3'b000;
        return {c, m_mode[k] == M_PLAY, m_guest[k], m_id[k],
                4'(m_score[k] / 10), 4'(m_score[k] % 10)};
    endfunction

    function automatic logic [31:0] exp_all();
        return {exp_one(0), exp_one(1)};
    endfunction

    function automatic logic [31:0] obs_all();
        return {ctrl_a, busy_a, guest_a, id_a, tens_a, ones_a,
                ctrl_b, busy_b, guest_b, id_b, tens_b, ones_b};
    endfunction

    function automatic bit quiet();
        return (m_mode[0] == M_IDLE || m_mode[0] == M_SHOW) &&
               (m_mode[1] == M_IDLE || m_mode[1] == M_SHOW);
    endfunction

    task automatic cyc(input logic s, input logic h, input logic m);
        start = s;
        hit   = h;
        miss  = m;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_sched();
        for (int i = 0; i < 256; i++) begin
            sch_s[i] = 1'b0;
            sch_h[i] = 1'b0;
            sch_m[i] = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        cyc(0, 1'b1, 1'b0);
        cyc(0, 1'b0, 1'b1);
        vectors++;
        if (obs_all() !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_state got=%h exp=%h", obs_all(), 32'h0);
        end
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, 1'($urandom), 1'($urandom));
            vectors++;
            if (obs_all() !== exp_all()) begin
                miscompares++;
                $display("FAIL reset_idle cycle %0d got=%h exp=%h", i, obs_all(), exp_all());
            end
        end
        cyc(0, 0, 0);
        vectors++;
        if (obs_all() !== 32'h0) begin
            miscompares++;
            $display("FAIL idle_after_reset got=%h exp=%h", obs_all(), 32'h0);
        end
        $display("reset: idle outputs %h", obs_all());
    endtask

    task automatic test_basic();
        int pos, busy_cnt, store_cnt;
        for (int i = 0; i < 400 && !quiet(); i++) cyc(0, 0, 0);
        clear_sched();
        playerID = 3'b101;
        guestIn  = 1'b1;
        sch_s[0] = 1'b1;
        pos = 4;
        for (int k = 0; k < 12; k++) begin
            sch_h[pos] = 1'b1;
            pos += 2 + int'($urandom_range(1, 0));
        end
        busy_cnt  = 0;
        store_cnt = 0;
        for (int i = 0; i < 70; i++) begin
            cyc(sch_s[i], sch_h[i], sch_m[i]);
            vectors++;
            if (obs_all() !== exp_all()) begin
                miscompares++;
                $display("FAIL basic cycle %0d got=%h exp=%h", i, obs_all(), exp_all());
            end
            if (busy_a) busy_cnt++;
            if (ctrl_a == 3'b001) begin
                store_cnt++;
                vectors++;
                if ({tens_a, ones_a, id_a, guest_a} !== {8'h12, 3'b101, 1'b1}) begin
                    miscompares++;
                    $display("FAIL basic_store got=%h%h id=%b g=%b exp=12 id=101 g=1",
                             tens_a, ones_a, id_a, guest_a);
                end
            end
        end
        vectors++;
        if (busy_cnt !== RA) begin
            miscompares++;
            $display("FAIL basic_busy_len got=%0d exp=%0d", busy_cnt, RA);
        end
        vectors++;
        if (store_cnt !== 1) begin
            miscompares++;
            $display("FAIL basic_store_count got=%0d exp=1", store_cnt);
        end
        $display("basic: id=%b guest=%b score=%h%h cmd=%b", id_a, guest_a, tens_a, ones_a, ctrl_a);
    endtask

    task automatic test_bcd_saturation();
        for (int i = 0; i < 400 && !quiet(); i++) cyc(0, 0, 0);
        vectors++;
        if (!quiet()) begin
            miscompares++;
            $display("FAIL sat_drain timeout modes a=%0d b=%0d", m_mode[0], m_mode[1]);
        end
        clear_sched();
        playerID = 3'($urandom);
        guestIn  = 1'($urandom);
        sch_s[0] = 1'b1;
        for (int k = 1; k <= 105; k++) sch_h[2 + 2 * k] = 1'b1;
        for (int i = 0; i < 240; i++) begin
            cyc(sch_s[i], sch_h[i], sch_m[i]);
            vectors++;
            if (obs_all() !== exp_all()) begin
                miscompares++;
                $display("FAIL sat cycle %0d got=%h exp=%h", i, obs_all(), exp_all());
            end
            if (i == 21 || i == 23 || i == 201 || i == 239) begin
                vectors++;
                if ({tens_b, ones_b} !== ((i == 21) ? 8'h09 : (i == 23) ? 8'h10 : 8'h99)) begin
                    miscompares++;
                    $display("FAIL sat_digits cycle %0d got=%h%h", i, tens_b, ones_b);
                end
            end
        end
        $display("saturation: long round score=%h%h cmd=%b", tens_b, ones_b, ctrl_b);
    endtask

    task automatic test_penalty();
        for (int i = 0; i < 400 && !quiet(); i++) cyc(0, 0, 0);
        clear_sched();
        sch_s[0] = 1'b1;
        for (int k = 0; k < 3; k++)  sch_m[4 + 2 * k] = 1'b1;
        for (int k = 0; k < 10; k++) sch_h[10 + 2 * k] = 1'b1;
        sch_m[30] = 1'b1;
        for (int i = 0; i < 60; i++) begin
            cyc(sch_s[i], sch_h[i], sch_m[i]);
            vectors++;
            if (obs_all() !== exp_all()) begin
                miscompares++;
                $display("FAIL penalty cycle %0d got=%h exp=%h", i, obs_all(), exp_all());
            end
            if (i == 9 || i == 29 || i == 31 || i == 59) begin
                vectors++;
                if ({tens_a, ones_a, tens_b, ones_b} !==
                    ((i == 9) ? 16'h0000 : (i == 29) ? 16'h1010 : 16'h0910)) begin
                    miscompares++;
                    $display("FAIL penalty_digits cycle %0d got a=%h%h b=%h%h",
                             i, tens_a, ones_a, tens_b, ones_b);
                end
            end
        end
        $display("penalty: a=%h%h b=%h%h", tens_a, ones_a, tens_b, ones_b);
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 400 && !quiet(); i++) cyc(0, 0, 0);
        clear_sched();
        sch_s[0] = 1'b1;
        for (int k = 0; k < 5; k++) sch_h[4 + 2 * k] = 1'b1;
        sch_h[14] = 1'b1;
        sch_m[14] = 1'b1;
        for (int i = 16; i < 36; i++) sch_h[i] = 1'b1;
        for (int i = 0; i < 45; i++) begin
            cyc(sch_s[i], sch_h[i], sch_m[i]);
            vectors++;
            if (obs_all() !== exp_all()) begin
                miscompares++;
                $display("FAIL simul cycle %0d got=%h exp=%h", i, obs_all(), exp_all());
            end
            if (i == 13 || i == 15 || i == 30 || i == 37) begin
                vectors++;
                if ({tens_a, ones_a, tens_b, ones_b} !==
                    ((i == 13) ? 16'h0505 : (i == 15) ? 16'h0506 : 16'h0607)) begin
                    miscompares++;
                    $display("FAIL simul_digits cycle %0d got a=%h%h b=%h%h",
                             i, tens_a, ones_a, tens_b, ones_b);
                end
            end
        end
        $display("simultaneous: a=%h%h b=%h%h", tens_a, ones_a, tens_b, ones_b);
    endtask

    task automatic test_back_to_back();
        int busy_cnt, store_cnt;
        logic [2:0] new_id;
        logic       new_guest;
        for (int i = 0; i < 400 && !quiet(); i++) cyc(0, 0, 0);
        clear_sched();
        new_id    = 3'($urandom);
        new_guest = ~guestIn;
        sch_s[0]  = 1'b1;
        sch_s[15] = 1'b1;
        sch_h[20] = 1'b1;
        sch_h[22] = 1'b1;
        sch_h[24] = 1'b1;
        sch_s[60] = 1'b1;
        sch_h[66] = 1'b1;
        sch_h[68] = 1'b1;
        for (int i = 77; i < 200; i++) begin
            sch_h[i] = 1'($urandom);
            sch_m[i] = 1'($urandom);
        end
        busy_cnt  = 0;
        store_cnt = 0;
        for (int i = 0; i < 200; i++) begin
            if (i == 58) begin
                playerID = new_id;
                guestIn  = new_guest;
            end
            rst = !(i == 75 || i == 76);
            cyc(sch_s[i], sch_h[i], sch_m[i]);
            vectors++;
            if (obs_all() !== exp_all()) begin
                miscompares++;
                $display("FAIL b2b cycle %0d got=%h exp=%h", i, obs_all(), exp_all());
            end
            if (i < 60 && busy_a) busy_cnt++;
            if (i >= 75 && (ctrl_a == 3'b001 || ctrl_b == 3'b001)) store_cnt++;
            if (i == 52) begin
                vectors++;
                if (ctrl_a !== 3'b001) begin
                    miscompares++;
                    $display("FAIL b2b_store_time got=%b exp=001", ctrl_a);
                end
            end
            if (i == 61) begin
                vectors++;
                if (ctrl_a !== 3'b100) begin
                    miscompares++;
                    $display("FAIL b2b_restart_clear got=%b exp=100", ctrl_a);
                end
            end
            if (i == 62) begin
                vectors++;
                if ({busy_a, tens_a, ones_a, id_a, guest_a} !== {1'b1, 8'h00, new_id, new_guest}) begin
                    miscompares++;
                    $display("FAIL b2b_restart_play got busy=%b score=%h%h id=%b g=%b exp busy=1 score=00 id=%b g=%b",
                             busy_a, tens_a, ones_a, id_a, guest_a, new_id, new_guest);
                end
            end
            if (i == 76 || i == 199) begin
                vectors++;
                if ({ctrl_a, busy_a, guest_a, id_a, tens_a, ones_a} !== 16'h0) begin
                    miscompares++;
                    $display("FAIL b2b_after_reset cycle %0d got=%h exp=0000", i,
                             {ctrl_a, busy_a, guest_a, id_a, tens_a, ones_a});
                end
            end
        end
        rst = 1'b1;
        vectors++;
        if (busy_cnt !== RA) begin
            miscompares++;
            $display("FAIL b2b_round_len got=%0d exp=%0d", busy_cnt, RA);
        end
        vectors++;
        if (store_cnt !== 0) begin
            miscompares++;
            $display("FAIL b2b_store_after_reset got=%0d exp=0", store_cnt);
        end
        $display("back_to_back: restart id=%b, post-reset cmd=%b score=%h%h", new_id, ctrl_a, tens_a, ones_a);
    endtask

    initial begin
        clear_sched();
        test_reset();
        test_basic();
        test_bcd_saturation();
        test_penalty();
        test_simultaneous();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
